// File: rtl/qbus_pkg.sv
// Shared types for the QBUS DMA master: FSM states, command codes, bus drive bundle.
// No logic here; latency/backpressure live in the modules that import it.
package qbus_pkg;

  localparam int DEF_SETUP_CYC   = 2;
  localparam int DEF_TIMEOUT_CYC = 64;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_REQ,
    ST_WBUS,
    ST_ADDR,
    ST_HOLD,
    ST_STRB,
    ST_WRPLY,
    ST_WEND,
    ST_FIN
  } state_t;

  typedef enum logic [1:0] {
    CMD_DATI  = 2'd0,
    CMD_DATO  = 2'd1,
    CMD_DATOB = 2'd2
  } cmd_t;

  typedef struct packed {
    cmd_t        cmd;
    logic [15:0] addr;
    logic [15:0] wdata;
  } xfer_t;

  // Everything the master drives onto the bus, all in bus (inverted) polarity
  typedef struct packed {
    logic        dmr_n;
    logic        sack_n;
    logic        sync_n;
    logic        din_n;
    logic        dout_n;
    logic        wtbt_n;
    logic        ad_oe;
    logic [15:0] ad_n_out;
  } bus_t;

  localparam bus_t BUS_IDLE = '{
    dmr_n:    1'b1,
    sack_n:   1'b1,
    sync_n:   1'b1,
    din_n:    1'b1,
    dout_n:   1'b1,
    wtbt_n:   1'b1,
    ad_oe:    1'b0,
    ad_n_out: 16'hFFFF
  };

  function automatic cmd_t cmd_of(input logic wr, input logic byt);
    if (!wr) return CMD_DATI;
    return byt ? CMD_DATOB : CMD_DATO;
  endfunction

endpackage

// File: rtl/qbus_sync2.sv
// Two-flop synchronizer for asynchronous active-low bus lines; resets to the idle (high) level.
// Latency: 2 clocks. No backpressure.
module qbus_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/qbus_dma_master.sv
// Single-transfer QBUS master: arbitrates (DMR/DMGI/SACK), runs one DATI/DATO(B), releases, reports ack/err.
// Latency: bus inputs seen 2 clocks late through synchronizers; client holds req, accepted only while idle.
module qbus_dma_master
  import qbus_pkg::*;
#(
  parameter int SETUP_CYC   = DEF_SETUP_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic        pin_clk,
  input  logic        pin_dclo_n,
  input  logic        pin_init_n,
  input  logic        req,
  input  logic        req_wr,
  input  logic        req_byte,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        busy,
  output logic        ack,
  output logic        err,
  output logic [15:0] rdata,
  output logic        pin_dmr_n,
  input  logic        pin_dmgi_n,
  output logic        pin_sack_n,
  input  logic        pin_rply_n,
  input  logic [15:0] pin_ad_n_in,
  output logic [15:0] pin_ad_n_out,
  output logic        pin_ad_oe,
  output logic        pin_sync_n,
  output logic        pin_din_n,
  output logic        pin_dout_n,
  output logic        pin_wtbt_n
);

  localparam int CW = $clog2((TIMEOUT_CYC > SETUP_CYC) ? TIMEOUT_CYC : SETUP_CYC) + 1;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  xfer_t         xfer, xfer_nxt;
  bus_t          bus, bus_nxt;
  logic          busy_nxt, ack_nxt, err_nxt, errf, errf_nxt;
  logic [15:0]   rdata_nxt;
  logic          dmgi_n_s, rply_n_s, init_n_s;

  qbus_sync2 u_sync_dmgi (.clk(pin_clk), .rst_n(pin_dclo_n), .d(pin_dmgi_n), .q(dmgi_n_s));
  qbus_sync2 u_sync_rply (.clk(pin_clk), .rst_n(pin_dclo_n), .d(pin_rply_n), .q(rply_n_s));
  qbus_sync2 u_sync_init (.clk(pin_clk), .rst_n(pin_dclo_n), .d(pin_init_n), .q(init_n_s));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    xfer_nxt  = xfer;
    bus_nxt   = bus;
    busy_nxt  = busy;
    errf_nxt  = errf;
    rdata_nxt = rdata;
    ack_nxt   = 1'b0;
    err_nxt   = 1'b0;
    if (state != ST_IDLE && !init_n_s) begin
      // INIT aborts from anywhere: drop the bus in one clock
      bus_nxt   = BUS_IDLE;
      busy_nxt  = 1'b0;
      err_nxt   = 1'b1;
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req && init_n_s) begin
            xfer_nxt      = '{cmd: cmd_of(req_wr, req_byte), addr: req_addr, wdata: req_wdata};
            busy_nxt      = 1'b1;
            errf_nxt      = 1'b0;
            bus_nxt.dmr_n = 1'b0;
            state_nxt     = ST_REQ;
          end
        end
        ST_REQ: begin
          if (!dmgi_n_s) begin
            bus_nxt.sack_n = 1'b0;
            bus_nxt.dmr_n  = 1'b1;
            state_nxt      = ST_WBUS;
          end
        end
        ST_WBUS: begin
          if (rply_n_s) begin
            bus_nxt.ad_oe    = 1'b1;
            bus_nxt.ad_n_out = ~xfer.addr;
            bus_nxt.wtbt_n   = (xfer.cmd == CMD_DATI);
            cnt_nxt          = '0;
            state_nxt        = ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (cnt == CW'(SETUP_CYC - 1)) begin
            bus_nxt.sync_n = 1'b0;
            state_nxt      = ST_HOLD;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        ST_HOLD: begin
          if (xfer.cmd == CMD_DATI) begin
            bus_nxt.ad_oe    = 1'b0;
            bus_nxt.ad_n_out = 16'hFFFF;
            bus_nxt.wtbt_n   = 1'b1;
          end else begin
            bus_nxt.ad_n_out = ~xfer.wdata;
            bus_nxt.wtbt_n   = (xfer.cmd != CMD_DATOB);
          end
          state_nxt = ST_STRB;
        end
        ST_STRB: begin
          if (xfer.cmd == CMD_DATI) bus_nxt.din_n = 1'b0;
          else                      bus_nxt.dout_n = 1'b0;
          cnt_nxt   = '0;
          state_nxt = ST_WRPLY;
        end
        ST_WRPLY: begin
          if (!rply_n_s) begin
            if (xfer.cmd == CMD_DATI) rdata_nxt = ~pin_ad_n_in;
            bus_nxt.din_n  = 1'b1;
            bus_nxt.dout_n = 1'b1;
            state_nxt      = ST_WEND;
          end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
            bus_nxt.din_n  = 1'b1;
            bus_nxt.dout_n = 1'b1;
            errf_nxt       = 1'b1;
            err_nxt        = 1'b1;
            state_nxt      = ST_FIN;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        ST_WEND: begin
          if (rply_n_s) state_nxt = ST_FIN;
        end
        ST_FIN: begin
          bus_nxt   = BUS_IDLE;
          ack_nxt   = !errf;
          busy_nxt  = 1'b0;
          state_nxt = ST_IDLE;
        end
        default: begin
          bus_nxt   = BUS_IDLE;
          busy_nxt  = 1'b0;
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge pin_clk or negedge pin_dclo_n) begin
    if (!pin_dclo_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      xfer  <= '0;
      bus   <= BUS_IDLE;
      busy  <= 1'b0;
      ack   <= 1'b0;
      err   <= 1'b0;
      errf  <= 1'b0;
      rdata <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      xfer  <= xfer_nxt;
      bus   <= bus_nxt;
      busy  <= busy_nxt;
      ack   <= ack_nxt;
      err   <= err_nxt;
      errf  <= errf_nxt;
      rdata <= rdata_nxt;
    end
  end

  assign pin_dmr_n    = bus.dmr_n;
  assign pin_sack_n   = bus.sack_n;
  assign pin_sync_n   = bus.sync_n;
  assign pin_din_n    = bus.din_n;
  assign pin_dout_n   = bus.dout_n;
  assign pin_wtbt_n   = bus.wtbt_n;
  assign pin_ad_oe    = bus.ad_oe;
  assign pin_ad_n_out = bus.ad_n_out;

endmodule

// File: tb/tb_qbus_dma_master.sv
// Bench for qbus_dma_master: arbiter + memory slave model, scoreboard of expected ack/err/rdata.
module tb_qbus_dma_master;

  localparam int TB_SETUP = 3;
  localparam int TB_TMO   = 24;

  logic        pin_clk = 1'b0;
  logic        pin_dclo_n = 1'b0;
  logic        pin_init_n = 1'b1;
  logic        req = 1'b0, req_wr = 1'b0, req_byte = 1'b0;
  logic [15:0] req_addr = '0, req_wdata = '0;
  logic        busy, ack, err;
  logic [15:0] rdata;
  logic        pin_dmr_n, pin_sack_n, pin_ad_oe;
  logic        pin_dmgi_n = 1'b1, pin_rply_n = 1'b1;
  logic [15:0] pin_ad_n_in = 16'hFFFF, pin_ad_n_out;
  logic        pin_sync_n, pin_din_n, pin_dout_n, pin_wtbt_n;

  qbus_dma_master #(.SETUP_CYC(TB_SETUP), .TIMEOUT_CYC(TB_TMO)) dut (
    .pin_clk(pin_clk), .pin_dclo_n(pin_dclo_n), .pin_init_n(pin_init_n),
    .req(req), .req_wr(req_wr), .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy), .ack(ack), .err(err), .rdata(rdata),
    .pin_dmr_n(pin_dmr_n), .pin_dmgi_n(pin_dmgi_n), .pin_sack_n(pin_sack_n), .pin_rply_n(pin_rply_n),
    .pin_ad_n_in(pin_ad_n_in), .pin_ad_n_out(pin_ad_n_out), .pin_ad_oe(pin_ad_oe),
    .pin_sync_n(pin_sync_n), .pin_din_n(pin_din_n), .pin_dout_n(pin_dout_n), .pin_wtbt_n(pin_wtbt_n)
  );

  always #5 pin_clk = ~pin_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic        err;
    logic        chk_rd;
    logic [15:0] rd;
  } exp_t;

  exp_t sbq[$];
  exp_t sb_e;

  task automatic push(input logic e_err, input logic e_chk, input logic [15:0] e_rd);
    exp_t e;
    e.err = e_err; e.chk_rd = e_chk; e.rd = e_rd;
    sbq.push_back(e);
  endtask

  // slave / arbiter model state
  logic [15:0] mem [0:1023];
  int          gnt_dly = 5, rply_dly = 3, gcnt = 0, rcnt = 0;
  logic        gnt_hold = 1'b0;
  logic        prev_sync = 1'b1, s_sel = 1'b0;
  logic [15:0] s_addr = '0, d_dat = '0;
  logic        a_wtbt = 1'b1, d_wtbt = 1'b1;
  int          sync_falls = 0, setup_cnt = 0, setup_seen = 0, dout_lo = 0;

  function automatic int widx(input logic [15:0] a);
    return int'(a[10:1]);
  endfunction

  always @(negedge pin_clk) begin
    if (pin_dclo_n) begin
      if (!pin_sack_n || pin_dmr_n) begin
        pin_dmgi_n = 1'b1;
        gcnt = 0;
      end else if (!gnt_hold) begin
        if (gcnt >= gnt_dly) pin_dmgi_n = 1'b0;
        else gcnt++;
      end
      if (prev_sync && !pin_sync_n) begin
        s_addr = ~pin_ad_n_out;
        s_sel  = (s_addr < 16'o004000);
        a_wtbt = pin_wtbt_n;
        sync_falls++;
        setup_seen = setup_cnt;
      end
      if (!prev_sync && pin_sync_n) begin
        chk("sync_rel_after_rply", pin_rply_n, 1);
        s_sel = 1'b0;
      end
      prev_sync = pin_sync_n;
      setup_cnt = (pin_ad_oe && pin_sync_n) ? setup_cnt + 1 : 0;
      if (!pin_dout_n) dout_lo++;
      if (s_sel && (!pin_din_n || !pin_dout_n)) begin
        if (rcnt == 0 && !pin_dout_n) begin
          d_dat  = ~pin_ad_n_out;
          d_wtbt = pin_wtbt_n;
        end
        rcnt++;
        if (rcnt == rply_dly && pin_rply_n) begin
          if (!pin_din_n) pin_ad_n_in = ~mem[widx(s_addr)];
          else if (!d_wtbt) begin
            if (s_addr[0]) mem[widx(s_addr)][15:8] = d_dat[15:8];
            else           mem[widx(s_addr)][7:0]  = d_dat[7:0];
          end else mem[widx(s_addr)] = d_dat;
          pin_rply_n = 1'b0;
        end
      end else if (pin_din_n && pin_dout_n) begin
        pin_rply_n  = 1'b1;
        pin_ad_n_in = 16'hFFFF;
        rcnt = 0;
      end
    end
  end

  // completion monitor
  int   done_cnt = 0, dmr_falls = 0, sack_falls = 0, low_run = 0, busy_gap = 0;
  logic prev_dmr = 1'b1, prev_sack = 1'b1;

  always @(negedge pin_clk) begin
    if (pin_dclo_n) begin
      if (prev_dmr && !pin_dmr_n) dmr_falls++;
      if (prev_sack && !pin_sack_n) sack_falls++;
      if (!busy) low_run++;
      else begin
        if (low_run > 0) busy_gap = low_run;
        low_run = 0;
      end
      if (ack || err) begin
        done_cnt++;
        if (sbq.size() == 0) chk("sb_unexpected", {30'd0, ack, err}, 0);
        else begin
          sb_e = sbq.pop_front();
          chk("sb_err", err, sb_e.err);
          chk("sb_ack", ack, !sb_e.err);
          if (sb_e.chk_rd) chk("sb_rdata", rdata, sb_e.rd);
        end
      end
    end
    prev_dmr  = pin_dmr_n;
    prev_sack = pin_sack_n;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge pin_clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic byt, input logic [15:0] a, input logic [15:0] d);
    req_wr = wr; req_byte = byt; req_addr = a; req_wdata = d;
    req = 1'b1;
    tick(1);
    req = 1'b0;
  endtask

  task automatic wait_done(input int target, input string tag);
    int k = 0;
    while (done_cnt < target && k < 3000) begin
      tick(1);
      k++;
    end
    chk(tag, done_cnt, target);
  endtask

  task automatic wait_busy(input logic v, input string tag);
    int k = 0;
    while (busy !== v && k < 1000) begin
      tick(1);
      k++;
    end
    chk(tag, busy, v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, d0, k0, bad, k;
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    mem[widx(16'o001000)] = 16'o123456;

    tick(3);
    chk("rst_strobes", {pin_dmr_n, pin_sack_n, pin_sync_n, pin_din_n, pin_dout_n, pin_wtbt_n}, 6'h3F);
    chk("rst_ad_oe", pin_ad_oe, 0);
    chk("rst_ad_out", pin_ad_n_out, 16'hFFFF);
    chk("rst_busy", busy, 0);
    chk("rst_ack_err", {ack, err}, 0);
    chk("rst_rdata", rdata, 0);
    pin_dclo_n = 1'b1;
    tick(3);

    // DATI with delayed grant and reply
    gnt_dly = 5; rply_dly = 3;
    push(1'b0, 1'b1, 16'o123456);
    issue(1'b0, 1'b0, 16'o001000, 16'h0000);
    wait_done(1, "t1_done");
    chk("t1_setup_cycles", setup_seen, TB_SETUP);
    chk("t1_wtbt_addr", a_wtbt, 1);
    chk("t1_sack_end", pin_sack_n, 1);
    chk("t1_busy_end", busy, 0);

    // DATOB to the odd byte of the same word, then read it back
    push(1'b0, 1'b0, 16'h0000);
    issue(1'b1, 1'b1, 16'o001001, 16'o000252);
    wait_done(2, "t2_done");
    chk("t2_wtbt_addr", a_wtbt, 0);
    chk("t2_wtbt_data", d_wtbt, 0);
    chk("t2_data_bus", d_dat, 16'o000252);
    chk("t2_mem", mem[widx(16'o001000)], 16'o000056);
    push(1'b0, 1'b1, 16'o000056);
    issue(1'b0, 1'b0, 16'o001000, 16'h0000);
    wait_done(3, "t2_rb_done");

    // DATO to an address nobody answers
    tick(1);
    dout_lo = 0;
    push(1'b1, 1'b0, 16'h0000);
    issue(1'b1, 1'b0, 16'o170000, 16'o177777);
    wait_done(4, "t3_done");
    tick(2);
    chk("t3_dout_low_cycles", dout_lo, TB_TMO);
    chk("t3_bus_idle", {pin_dmr_n, pin_sack_n, pin_sync_n, pin_din_n, pin_dout_n, pin_wtbt_n, pin_ad_oe}, 7'b1111110);
    chk("t3_busy", busy, 0);

    // INIT during the reply wait of a DATI
    rply_dly = 50;
    push(1'b1, 1'b0, 16'h0000);
    issue(1'b0, 1'b0, 16'o001002, 16'h0000);
    k = 0;
    while (pin_din_n && k < 200) begin
      tick(1);
      k++;
    end
    chk("t4_din_seen", pin_din_n, 0);
    tick(2);
    pin_init_n = 1'b0;
    tick(3);
    chk("t4_strobes_off", {pin_dmr_n, pin_sack_n, pin_sync_n, pin_din_n, pin_dout_n, pin_wtbt_n}, 6'h3F);
    chk("t4_ad_oe", pin_ad_oe, 0);
    chk("t4_busy", busy, 0);
    wait_done(5, "t4_done");
    req_wr = 1'b0; req_addr = 16'o001000;
    req = 1'b1;
    tick(4);
    chk("t4_no_accept_in_init", busy, 0);
    req = 1'b0;
    pin_init_n = 1'b1;
    tick(4);
    rply_dly = 3;
    push(1'b0, 1'b1, 16'o000056);
    issue(1'b0, 1'b0, 16'o001000, 16'h0000);
    wait_done(6, "t4_after_done");

    // grant withheld for 100 clocks
    gnt_hold = 1'b1;
    s0 = sync_falls;
    push(1'b0, 1'b0, 16'h0000);
    issue(1'b1, 1'b0, 16'o000200, 16'o052525);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (pin_dmr_n !== 1'b0 || busy !== 1'b1) bad++;
    end
    chk("t5_dmr_busy_held", bad, 0);
    chk("t5_no_sync", sync_falls - s0, 0);
    gnt_hold = 1'b0;
    wait_done(7, "t5_done");
    chk("t5_mem", mem[widx(16'o000200)], 16'o052525);

    // back-to-back word writes with req held high
    gnt_dly = 2; rply_dly = 2;
    d0 = dmr_falls; k0 = sack_falls;
    push(1'b0, 1'b0, 16'h0000);
    push(1'b0, 1'b0, 16'h0000);
    req_wr = 1'b1; req_byte = 1'b0; req_addr = 16'o000100; req_wdata = 16'o111111;
    req = 1'b1;
    wait_busy(1'b1, "t6_first_accept");
    req_addr = 16'o000102; req_wdata = 16'o022222;
    wait_busy(1'b0, "t6_first_release");
    wait_busy(1'b1, "t6_second_accept");
    req = 1'b0;
    wait_done(9, "t6_done");
    chk("t6_busy_gap", busy_gap, 1);
    chk("t6_dmr_seqs", dmr_falls - d0, 2);
    chk("t6_sack_seqs", sack_falls - k0, 2);
    chk("t6_mem0", mem[widx(16'o000100)], 16'o111111);
    chk("t6_mem1", mem[widx(16'o000102)], 16'o022222);

    tick(5);
    chk("sb_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
